// File: rtl/mci_mbox_sram_arb.sv
// Two-requester arbiter for one MCI mailbox SRAM port: round-robin with lock override,
// fixed-latency read return to the issuing requester, and a saturating contention counter.
module mci_mbox_sram_arb #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  input  logic              lock_valid,
  input  logic              lock_owner,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [15:0]       conflict_cnt
);

  logic              rr_ptr_q, rr_ptr_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0] pipe_src_q, pipe_src_d;

  logic cand0, cand1, gnt_vld, gnt_idx, gnt_rd;
  logic rsp_vld, rsp_src;

  // Lock holder alone is eligible; reset suppresses every grant.
  always_comb begin
    cand0   = rst_b && req0_valid && (!lock_valid || !lock_owner);
    cand1   = rst_b && req1_valid && (!lock_valid || lock_owner);
    gnt_vld = cand0 || cand1;
    gnt_idx = (cand0 && cand1) ? rr_ptr_q : cand1;
  end

  always_comb begin
    req0_ready = gnt_vld && !gnt_idx;
    req1_ready = gnt_vld && gnt_idx;
    sram_cs    = gnt_vld;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (gnt_vld) begin
      sram_we    = gnt_idx ? req1_write : req0_write;
      sram_addr  = gnt_idx ? req1_addr  : req0_addr;
      sram_wdata = gnt_idx ? req1_wdata : req0_wdata;
    end
    gnt_rd = gnt_vld && !sram_we;
  end

  always_comb begin
    rr_ptr_d       = gnt_vld ? !gnt_idx : rr_ptr_q;
    conflict_cnt_d = conflict_cnt_q;
    if (req0_valid && req1_valid && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
    pipe_vld_d    = pipe_vld_q;
    pipe_src_d    = pipe_src_q;
    pipe_vld_d[0] = gnt_rd;
    pipe_src_d[0] = gnt_idx;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_src_d[i] = pipe_src_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rr_ptr_q       <= 1'b0;
      conflict_cnt_q <= '0;
      pipe_vld_q     <= '0;
      pipe_src_q     <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
      pipe_vld_q     <= pipe_vld_d;
      pipe_src_q     <= pipe_src_d;
    end
  end

  // The last pipe stage lines up with the SRAM read data for that issue.
  always_comb begin
    rsp_vld      = rst_b && pipe_vld_q[RD_LAT-1];
    rsp_src      = pipe_src_q[RD_LAT-1];
    rsp0_valid   = rsp_vld && !rsp_src;
    rsp1_valid   = rsp_vld && rsp_src;
    rsp0_rdata   = rsp0_valid ? sram_rdata : '0;
    rsp1_rdata   = rsp1_valid ? sram_rdata : '0;
    conflict_cnt = rst_b ? conflict_cnt_q : '0;
  end

endmodule
